// File: rtl/ser16_tx_if.sv
// ser16_tx_if: parallel-load / serial-out bus between a word source and ser16_tx.
interface ser16_tx_if;
  logic [15:0] in;
  logic        load;
  logic        ready;
  logic        sout;
  logic        sframe;
  logic        done;
  modport master (output in, load, input ready, sout, sframe, done);
  modport slave (input in, load, output ready, sout, sframe, done);
endinterface

// File: rtl/ser16_tx.sv
// ser16_tx: 16-bit parallel-to-serial transmitter with frame strobe and done pulse.
module ser16_tx #(
  parameter bit LSB_FIRST = 1'b1,
  parameter bit INVERT    = 1'b0
) (
  input logic        clk,
  input logic        reset,
  ser16_tx_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e      state_q;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  cnt_q;
  logic        ready_q, sout_q, sframe_q, done_q;
  logic        first_bit, next_bit;
  // sout is registered one bit ahead: the accept edge loads bit 0, each SHIFT edge loads the next
  always_comb begin
    sh_d      = LSB_FIRST ? {1'b0, sh_q[15:1]} : {sh_q[14:0], 1'b0};
    first_bit = (LSB_FIRST ? bus.in[0] : bus.in[15]) ^ INVERT;
    next_bit  = (LSB_FIRST ? sh_d[0] : sh_d[15]) ^ INVERT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.load) begin
          state_q  <= SHIFT;
          sh_q     <= bus.in;
          cnt_q    <= '0;
          ready_q  <= 1'b0;
          sframe_q <= 1'b1;
          sout_q   <= first_bit;
        end
        SHIFT: if (cnt_q == 4'd15) begin
          state_q  <= DONE;
          cnt_q    <= '0;
          sframe_q <= 1'b0;
          sout_q   <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + 4'd1;
          sh_q   <= sh_d;
          sout_q <= next_bit;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ready  = ready_q;
  assign bus.sout   = sout_q;
  assign bus.sframe = sframe_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_ser16_tx.sv
// tb_ser16_tx: drives three ser16_tx variants (LSB/plain, MSB/plain, LSB/inverted) with one stimulus stream.
module tb_ser16_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] in_s = '0;
  logic        rdy[3], so[3], sf[3], dn[3];
  logic        rst_q = 1'b1;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] expq[3][$];
  logic [15:0] rx[3];
  int          nbits[3] = '{0, 0, 0};
  bit          post[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    ser16_tx_if bus ();
    assign bus.in   = in_s;
    assign bus.load = load;
    assign rdy[g]   = bus.ready;
    assign so[g]    = bus.sout;
    assign sf[g]    = bus.sframe;
    assign dn[g]    = bus.done;
    ser16_tx #(.LSB_FIRST(g != 1), .INVERT(g == 2)) dut (.clk(clk), .reset(reset), .bus(bus));
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  function automatic logic [15:0] ser_model(logic [15:0] w, int g);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (g == 1 ? w[15-k] : w[k]) ^ (g == 2);
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: collects each frame and compares it against the queued word.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_q) begin
        check($sformatf("d%0d_rst_ready", g), rdy[g], 1);
        check($sformatf("d%0d_rst_sframe", g), sf[g], 0);
        check($sformatf("d%0d_rst_sout", g), so[g], 0);
        check($sformatf("d%0d_rst_done", g), dn[g], 0);
        if (nbits[g] > 0 && expq[g].size() > 0) void'(expq[g].pop_front());
        nbits[g] = 0;
        post[g]  = 0;
      end else if (sf[g]) begin
        check($sformatf("d%0d_shift_ready", g), rdy[g], 0);
        check($sformatf("d%0d_shift_done", g), dn[g], 0);
        if (nbits[g] < 16) rx[g][nbits[g]] = so[g];
        nbits[g]++;
      end else if (nbits[g] > 0) begin
        check($sformatf("d%0d_frame_len", g), nbits[g], 16);
        if (expq[g].size() == 0) check($sformatf("d%0d_unexpected_frame", g), 1, 0);
        else check($sformatf("d%0d_bits", g), rx[g], ser_model(expq[g].pop_front(), g));
        check($sformatf("d%0d_done_pulse", g), dn[g], 1);
        check($sformatf("d%0d_done_ready", g), rdy[g], 0);
        check($sformatf("d%0d_done_sout", g), so[g], 0);
        nbits[g] = 0;
        post[g]  = 1;
      end else begin
        check($sformatf("d%0d_idle_done", g), dn[g], 0);
        check($sformatf("d%0d_idle_sout", g), so[g], 0);
        if (post[g]) check($sformatf("d%0d_ready_after_done", g), rdy[g], 1);
        post[g] = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!rdy[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", rdy[0], 1);
  endtask

  task automatic push(logic [15:0] w);
    for (int g = 0; g < 3; g++) expq[g].push_back(w);
  endtask

  task automatic send(logic [15:0] w);
    wait_ready();
    in_s = w;
    load = 1'b1;
    push(w);
    @(negedge clk);
    load = 1'b0;
    in_s = 16'($urandom);
  endtask

  initial begin
    int t0, t1, n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send(16'hA5C3);
    send(16'h8000);
    send(16'h0000);
    send(16'hFFFF);
    // load held high through a whole frame: second word must land exactly 18 edges later
    wait_ready();
    in_s = 16'h00FF;
    load = 1'b1;
    push(16'h00FF);
    @(negedge clk);
    in_s = 16'hFFFF;
    push(16'hFFFF);
    t0 = cyc;
    n  = 0;
    while (sf[0] && n < 40) begin @(negedge clk); n++; end
    while (!sf[0] && n < 40) begin @(negedge clk); n++; end
    t1 = cyc;
    load = 1'b0;
    check("accept_spacing", t1 - t0, 18);
    // reset during data bit 7 aborts the frame; next load accepted right after
    send(16'hC3A5);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(16'h1234);
    // reset and load on the same edge: no frame may start
    wait_ready();
    reset = 1'b1;
    load  = 1'b1;
    in_s  = 16'hBEEF;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) send(16'($urandom));
    n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("d%0d_queue_drained", g), expq[g].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
